// File: rtl/garage_pkg.sv
// Shared types and default timing for the garage door request scheduler.
package garage_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_TRAVEL,
    S_DWELL,
    S_FAULT
  } sched_state_t;

  typedef enum logic {
    TGT_UP,
    TGT_DN
  } target_t;

  localparam int TIMEOUT_CYC_DEF   = 1000;
  localparam int AUTOCLOSE_CYC_DEF = 5000;

endpackage

// File: rtl/garage_rr_arbiter.sv
// Round-robin one-hot pick among request sources, starting at the pointer.
module garage_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               vld_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/garage_door_scheduler.sv
// Door request sequencer with travel watchdog and fault latch.
// Auto-close dwell is built only when GARAGE_AUTO_CLOSE_EN is defined.
module garage_door_scheduler
  import garage_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int CNT_W         = 16,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
  parameter int AUTOCLOSE_CYC = AUTOCLOSE_CYC_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  input  logic               UP_Max,
  input  logic               DN_Max,
  input  logic               UP_M,
  input  logic               DN_M,
  input  logic               fault_clr,
  output logic               Activate,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               fault
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  if (longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W) ||
      longint'(AUTOCLOSE_CYC) >= (longint'(1) << CNT_W)) begin : g_cfg_chk
    $error("garage_door_scheduler: cycle limits exceed counter width");
  end

`ifdef GARAGE_AUTO_CLOSE_EN
  localparam logic [CNT_W-1:0] AC_LAST = CNT_W'(AUTOCLOSE_CYC - 1);
`endif

  sched_state_t       st_q, st_d;
  target_t            tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]      ptr_q, ptr_d, nxt_ptr;
  logic               act_q, act_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_vld;
  logic               tgt_hit;

  garage_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .vld_o(arb_vld)
  );

  assign nxt_ptr = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign tgt_hit = (tgt_q == TGT_UP) ? UP_Max : DN_Max;

  always_comb begin
    st_d  = st_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    act_d = 1'b0;
    gnt_d = '0;
    // Both motor drives at once is a hard fault from any live state.
    if (st_q != S_FAULT && UP_M && DN_M) begin
      st_d = S_FAULT;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (UP_Max && DN_Max) begin
            st_d = S_FAULT;
          end else if ((UP_Max ^ DN_Max) && arb_vld) begin
            st_d  = S_GRANT;
            act_d = 1'b1;
            gnt_d = arb_gnt;
            ptr_d = nxt_ptr;
          end
        end
        S_GRANT: begin
          tgt_d = UP_Max ? TGT_DN : TGT_UP;
          cnt_d = '0;
          st_d  = S_TRAVEL;
        end
        S_TRAVEL: begin
          if (tgt_hit) begin
            cnt_d = '0;
`ifdef GARAGE_AUTO_CLOSE_EN
            st_d  = (tgt_q == TGT_UP) ? S_DWELL : S_IDLE;
`else
            st_d  = S_IDLE;
`endif
          end else if (cnt_q == TMO_LAST) begin
            st_d = S_FAULT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`ifdef GARAGE_AUTO_CLOSE_EN
        S_DWELL: begin
          if (!UP_Max) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end else if (arb_vld) begin
            st_d  = S_GRANT;
            act_d = 1'b1;
            gnt_d = arb_gnt;
            ptr_d = nxt_ptr;
          end else if (cnt_q == AC_LAST) begin
            st_d  = S_GRANT;
            act_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
        S_FAULT: begin
          if (fault_clr) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
    busy_d  = !(st_d inside {S_IDLE, S_FAULT});
    fault_d = (st_d == S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= S_IDLE;
      tgt_q   <= TGT_UP;
      cnt_q   <= '0;
      ptr_q   <= '0;
      act_q   <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign Activate = act_q;
  assign grant    = gnt_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_garage_door_scheduler.sv
// Directed vector table plus hand-written multi-cycle sequences.
module tb_garage_door_scheduler;

  localparam int TMO = 30;
  localparam int ACL = 8;
`ifdef GARAGE_AUTO_CLOSE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] req = '0;
  logic       UP_Max = 1'b0, DN_Max = 1'b0;
  logic       UP_M = 1'b0, DN_M = 1'b0;
  logic       fault_clr = 1'b0;
  logic       Activate;
  logic [2:0] grant;
  logic       busy, fault;

  int nvec = 0;
  int nmis = 0;

  garage_door_scheduler #(
    .NUM_REQ      (3),
    .CNT_W        (16),
    .TIMEOUT_CYC  (TMO),
    .AUTOCLOSE_CYC(ACL)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .UP_Max   (UP_Max),
    .DN_Max   (DN_Max),
    .UP_M     (UP_M),
    .DN_M     (DN_M),
    .fault_clr(fault_clr),
    .Activate (Activate),
    .grant    (grant),
    .busy     (busy),
    .fault    (fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] req;
    logic       up, dn, upm, dnm, clr;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic [2:0] r, logic u, logic d, logic um,
                              logic dm, logic c, logic [5:0] e, string n);
    vec_t v;
    v.req = r; v.up = u; v.dn = d; v.upm = um; v.dnm = dm; v.clr = c;
    v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [5:0] outs();
    return {Activate, grant, busy, fault};
  endfunction

  task automatic drive(logic [2:0] r, logic u, logic d);
    req = r; UP_Max = u; DN_Max = d;
    UP_M = 1'b0; DN_M = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic do_reset(logic u, logic d);
    drive(3'b000, u, d);
    RST = 1'b1;
    step();
    chk("reset_outs", 32'(outs()), 32'h0);
    RST = 1'b0;
  endtask

  task automatic wait_act(string name, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step();
      seen = Activate;
    end
    if (!seen) chk({name, "_timeout"}, 32'(Activate), 32'h1);
  endtask

  initial begin
    logic seen;

    tbl[0]  = mk(3'b001, 0, 0, 0, 0, 0, 6'b000000, "hold_nolimit");
    tbl[1]  = mk(3'b001, 1, 0, 0, 0, 0, 6'b100110, "grant_src0");
    tbl[2]  = mk(3'b000, 1, 0, 0, 0, 0, 6'b000010, "enter_travel_dn");
    tbl[3]  = mk(3'b010, 0, 0, 0, 0, 0, 6'b000010, "travel_ign_req");
    tbl[4]  = mk(3'b010, 0, 1, 0, 0, 0, 6'b000000, "close_done");
    tbl[5]  = mk(3'b010, 0, 1, 0, 0, 0, 6'b101010, "grant_src1");
    tbl[6]  = mk(3'b000, 0, 1, 0, 0, 0, 6'b000010, "enter_travel_up");
    tbl[7]  = mk(3'b000, 0, 0, 1, 1, 0, 6'b000001, "motor_fault");
    tbl[8]  = mk(3'b100, 0, 1, 0, 0, 0, 6'b000001, "fault_hold");
    tbl[9]  = mk(3'b100, 0, 1, 0, 0, 1, 6'b000000, "fault_clear");
    tbl[10] = mk(3'b100, 1, 1, 0, 0, 0, 6'b000001, "both_limits");
    tbl[11] = mk(3'b100, 1, 0, 0, 0, 1, 6'b000000, "fault_clear2");
    tbl[12] = mk(3'b100, 1, 0, 0, 0, 0, 6'b110010, "grant_src2");
    tbl[13] = mk(3'b000, 1, 0, 0, 0, 0, 6'b000010, "enter_travel_dn2");
    tbl[14] = mk(3'b000, 0, 1, 0, 0, 0, 6'b000000, "close_done2");
    tbl[15] = mk(3'b111, 0, 1, 0, 0, 0, 6'b100110, "ptr_wrap_src0");

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; UP_Max = tbl[i].up; DN_Max = tbl[i].dn;
      UP_M = tbl[i].upm; DN_M = tbl[i].dnm; fault_clr = tbl[i].clr;
      step();
      chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
    end

    // Opening travel: pulse lasts one cycle, up limit at cycle 20.
    do_reset(1'b0, 1'b1);
    drive(3'b001, 1'b0, 1'b1);
    step();
    chk("open_pulse", 32'(outs()), 32'b100110);
    drive(3'b000, 1'b0, 1'b1);
    step();
    chk("open_pulse_1cyc", 32'(Activate), 32'h0);
    drive(3'b000, 1'b0, 1'b0);
    for (int c = 2; c < 20; c++) step();
    chk("open_midtravel_busy", 32'(busy), 32'h1);
    drive(3'b000, 1'b1, 1'b0);
    step();
    chk("open_done", 32'({busy, fault}), 32'({AUTO, 1'b0}));

    // Held requests rotate through all sources, then back to source 0.
    do_reset(1'b1, 1'b0);
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wait_act("rr", seen);
      chk("rr_grant", 32'(grant), 32'(3'b001 << i));
      step();
      UP_Max = ~UP_Max; DN_Max = ~DN_Max;
      step();
    end
    wait_act("rr_wrap", seen);
    chk("rr_wrap_grant", 32'(grant), 32'h1);

    // Watchdog: stuck travel faults after TMO cycles with no pulse.
    do_reset(1'b1, 1'b0);
    drive(3'b001, 1'b1, 1'b0);
    step();
    chk("wd_pulse", 32'(Activate), 32'h1);
    drive(3'b010, 1'b1, 1'b0);
    step();
    seen = 1'b0;
    for (int c = 0; c < TMO - 1; c++) begin
      step();
      seen |= Activate;
    end
    chk("wd_pre_timeout", 32'({busy, fault}), 32'b10);
    step();
    seen |= Activate;
    chk("wd_timeout_fault", 32'({busy, fault}), 32'b01);
    for (int c = 0; c < 3; c++) begin
      step();
      seen |= Activate;
    end
    chk("wd_no_pulse", 32'(seen), 32'h0);
    fault_clr = 1'b1;
    step();
    chk("wd_clear", 32'(outs()), 32'h0);
    fault_clr = 1'b0;

    // Target limit in the timeout cycle wins over the watchdog.
    do_reset(1'b1, 1'b0);
    drive(3'b001, 1'b1, 1'b0);
    step();
    drive(3'b000, 1'b1, 1'b0);
    step();
    for (int c = 0; c < TMO - 1; c++) step();
    drive(3'b000, 1'b0, 1'b1);
    step();
    chk("wd_limit_wins", 32'(outs()), 32'h0);

    // Auto-close after an opening travel.
    do_reset(1'b0, 1'b1);
    drive(3'b001, 1'b0, 1'b1);
    step();
    drive(3'b000, 1'b0, 1'b1);
    step();
    drive(3'b000, 1'b1, 1'b0);
    step();
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("autoclose_c%0d", c), 32'({Activate, grant}),
          32'({(AUTO && c == ACL), 3'b000}));
    end

    // Reset mid-travel drops everything and restarts the pointer.
    do_reset(1'b1, 1'b0);
    drive(3'b001, 1'b1, 1'b0);
    step();
    drive(3'b000, 1'b1, 1'b0);
    step();
    step();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    req = 3'b011;
    RST = 1'b1;
    step();
    chk("rst_mid_travel", 32'(outs()), 32'h0);
    RST = 1'b0;
    step();
    chk("rst_regrant_src0", 32'(outs()), 32'b100110);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
